// File: rtl/aes_core_serial.sv
// Iterative AES-128 encrypt/decrypt core. One round key or one cipher round per clock.
// A request is captured when start=1 while ready=1. The result appears on data_out 22 edges
// later, when ready returns to 1.
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset (aborts any operation in progress)
//   start    - request pulse, sampled only while ready=1
//   enc_dec  - 1 = encrypt, 0 = decrypt (latched with start)
//   data_in  - 128-bit input block, byte 0 in bits [127:120]
//   key_in   - 128-bit cipher key, byte 0 in bits [127:120]
//   data_out - result register, changes only on completion or reset
//   ready    - 1 = idle with a valid result, 0 = busy
module aes_core_serial (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         enc_dec,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic [127:0] data_out,
    output logic         ready
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] KEYEXP = 3'd1;
    localparam logic [2:0] INIT   = 3'd2;
    localparam logic [2:0] ROUND  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box generated from inverse + affine map; yields the FIPS-197 table.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            b = s[127 - 8*k -: 8];
            r[127 - 8*k -: 8] = inv ? inv_sbox(b) : sbox(b);
        end
        return r;
    endfunction

    // Byte k sits at row k%4, column k/4; row r rotates left by r (right when inverse).
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        int row;
        int col;
        int src;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            row = k % 4;
            col = k / 4;
            src = inv ? (col + 4 - row) % 4 : (col + row) % 4;
            r[127 - 8*k -: 8] = s[127 - 8*(4*src + row) -: 8];
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            if (!inv) begin
                b0 = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
                b1 = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
                b2 = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
                b3 = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
            end else begin
                b0 = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
                b1 = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
                b2 = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
                b3 = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
            end
            r[127 - 32*c -: 32] = {b0, b1, b2, b3};
        end
        return r;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [2:0]   fsm_q, fsm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         dir_q, dir_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] dout_q, dout_d;
    logic [127:0] rk_q [11];
    logic [127:0] rk_d [11];

    logic [127:0] prev_rk;
    logic [31:0]  ks_tmp;
    logic [127:0] ks_next;
    logic [127:0] enc_t;
    logic [127:0] dec_t;

    // Next round key from the previous one.
    always_comb begin
        prev_rk = rk_q[cnt_q - 4'd1];
        ks_tmp  = sub_word({prev_rk[23:0], prev_rk[31:24]}) ^ {rcon(cnt_q), 24'h000000};
        ks_next[127:96] = prev_rk[127:96] ^ ks_tmp;
        ks_next[95:64]  = prev_rk[95:64] ^ ks_next[127:96];
        ks_next[63:32]  = prev_rk[63:32] ^ ks_next[95:64];
        ks_next[31:0]   = prev_rk[31:0] ^ ks_next[63:32];
    end

    // One cipher round in each direction; the final round drops (Inv)MixColumns.
    always_comb begin
        enc_t = shift_rows(sub_bytes(blk_q, 1'b0), 1'b0);
        if (cnt_q != 4'd10) enc_t = mix_columns(enc_t, 1'b0);
        enc_t = enc_t ^ rk_q[cnt_q];
        dec_t = sub_bytes(shift_rows(blk_q, 1'b1), 1'b1) ^ rk_q[4'd10 - cnt_q];
        if (cnt_q != 4'd10) dec_t = mix_columns(dec_t, 1'b1);
    end

    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        blk_d  = blk_q;
        dout_d = dout_q;
        rk_d   = rk_q;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    fsm_d    = KEYEXP;
                    cnt_d    = 4'd1;
                    dir_d    = enc_dec;
                    blk_d    = data_in;
                    rk_d[0]  = key_in;
                end
            end
            KEYEXP: begin
                rk_d[cnt_q] = ks_next;
                if (cnt_q == 4'd10) begin
                    fsm_d = INIT;
                    cnt_d = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            INIT: begin
                blk_d = blk_q ^ (dir_q ? rk_q[0] : rk_q[10]);
                cnt_d = 4'd1;
                fsm_d = ROUND;
            end
            ROUND: begin
                blk_d = dir_q ? enc_t : dec_t;
                if (cnt_q == 4'd10) begin
                    fsm_d = DONE;
                    cnt_d = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                dout_d = blk_q;
                fsm_d  = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q  <= IDLE;
            cnt_q  <= 4'd0;
            dir_q  <= 1'b0;
            blk_q  <= '0;
            dout_q <= '0;
            for (int i = 0; i < 11; i++) rk_q[i] <= '0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            blk_q  <= blk_d;
            dout_q <= dout_d;
            rk_q   <= rk_d;
        end
    end

    assign ready    = (fsm_q == IDLE);
    assign data_out = dout_q;

endmodule

// File: tb/tb_aes_core_serial.sv
// Self-checking bench for aes_core_serial: known-answer vectors, randomized requests checked
// against a byte-array AES reference model, busy-length and output-hold checks, mid-operation
// start and reset abort.
module tb_aes_core_serial;

    logic         clk;
    logic         rst;
    logic         start;
    logic         enc_dec;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic [127:0] data_out;
    logic         ready;

    aes_core_serial dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .enc_dec  (enc_dec),
        .data_in  (data_in),
        .key_in   (key_in),
        .data_out (data_out),
        .ready    (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [127:0] exp_q [$];
    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box by walking generator 3 and its inverse in parallel.
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic logic [127:0] ref_aes(input logic [127:0] key, input logic [127:0] blk,
                                             input logic enc);
        logic [7:0] w [176];
        logic [7:0] st [16];
        logic [7:0] tmp [16];
        logic [7:0] t [4];
        logic [7:0] a [4];
        logic [7:0] cf [4];
        logic [7:0] rc;
        logic [7:0] x;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            w[i]  = key[127 - 8*i -: 8];
            st[i] = blk[127 - 8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[4*(i-1) + j];
            if (i % 4 == 0) begin
                a = t;
                t[0] = sb[a[1]] ^ rc;
                t[1] = sb[a[2]];
                t[2] = sb[a[3]];
                t[3] = sb[a[0]];
                rc = xt(rc);
            end
            for (int j = 0; j < 4; j++) w[4*i + j] = w[4*(i-4) + j] ^ t[j];
        end
        if (enc) begin
            cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
            for (int k = 0; k < 16; k++) st[k] = st[k] ^ w[k];
            for (int rn = 1; rn <= 10; rn++) begin
                for (int k = 0; k < 16; k++) st[k] = sb[st[k]];
                tmp = st;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) st[r + 4*c] = tmp[r + 4*((c + r) % 4)];
                if (rn < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        for (int j = 0; j < 4; j++) a[j] = st[4*c + j];
                        for (int i = 0; i < 4; i++) begin
                            x = 8'h00;
                            for (int j = 0; j < 4; j++) x = x ^ gm(a[j], cf[(j - i + 4) % 4]);
                            st[4*c + i] = x;
                        end
                    end
                end
                for (int k = 0; k < 16; k++) st[k] = st[k] ^ w[16*rn + k];
            end
        end else begin
            cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
            for (int k = 0; k < 16; k++) st[k] = st[k] ^ w[160 + k];
            for (int rn = 9; rn >= 0; rn--) begin
                tmp = st;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) st[r + 4*((c + r) % 4)] = tmp[r + 4*c];
                for (int k = 0; k < 16; k++) st[k] = isb[st[k]] ^ w[16*rn + k];
                if (rn > 0) begin
                    for (int c = 0; c < 4; c++) begin
                        for (int j = 0; j < 4; j++) a[j] = st[4*c + j];
                        for (int i = 0; i < 4; i++) begin
                            x = 8'h00;
                            for (int j = 0; j < 4; j++) x = x ^ gm(a[j], cf[(j - i + 4) % 4]);
                            st[4*c + i] = x;
                        end
                    end
                end
            end
        end
        for (int k = 0; k < 16; k++) res[127 - 8*k -: 8] = st[k];
        return res;
    endfunction

    // Waits for idle, drives one request for a single capture edge, then scrambles inputs.
    task automatic issue(input logic [127:0] k, input logic [127:0] d, input logic e,
                         input logic [127:0] exp, input bit push);
        int t = 0;
        @(negedge clk);
        while (ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_timeout: ready=%b, required 1", ready);
            return;
        end
        key_in  = k;
        data_in = d;
        enc_dec = e;
        start   = 1'b1;
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        start   = 1'b0;
        data_in = rnd128();
        key_in  = rnd128();
        enc_dec = ~e;
    endtask

    // Monitor: compares each completion against the scoreboard and checks busy timing.
    initial begin
        logic         ready_prev;
        logic         rst_edge;
        logic [127:0] last_dout;
        logic [127:0] exp;
        int           busy_cnt;
        ready_prev = 1'b1;
        last_dout  = '0;
        busy_cnt   = 0;
        forever begin
            @(posedge clk);
            rst_edge = rst;
            #1;
            if (rst_edge) begin
                busy_cnt  = 0;
                last_dout = '0;
            end else if (ready === 1'b0) begin
                busy_cnt++;
                check("dout_hold", data_out, last_dout);
            end else if (ready === 1'b1 && ready_prev === 1'b0) begin
                check("busy_len", 128'(busy_cnt), 128'd22);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got %h, expected no completion", data_out);
                end else begin
                    exp = exp_q.pop_front();
                    check("result", data_out, exp);
                end
                last_dout = data_out;
                busy_cnt  = 0;
            end
            ready_prev = ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] k, d, c;
        logic         e;
        int           t;
        build_tables();
        rst     = 1'b1;
        start   = 1'b0;
        enc_dec = 1'b0;
        data_in = '0;
        key_in  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 128'(ready), 128'd1);
        check("reset_dout", data_out, '0);
        rst = 1'b0;

        issue(K1, P1, 1'b1, C1, 1'b1);
        issue(K1, C1, 1'b0, P1, 1'b1);
        issue(K2, P2, 1'b1, C2, 1'b1);
        issue(K2, C2, 1'b0, P2, 1'b1);
        issue('0, '0, 1'b1, CZ, 1'b1);
        issue('0, CZ, 1'b0, '0, 1'b1);

        // Start pulse with different inputs while busy must be ignored.
        issue(K2, P2, 1'b1, C2, 1'b1);
        repeat (5) @(negedge clk);
        start   = 1'b1;
        data_in = rnd128();
        enc_dec = 1'b0;
        @(negedge clk);
        start   = 1'b0;

        // Reset around cycle 10 of an operation aborts it with no result.
        issue(K1, P1, 1'b1, C1, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready", 128'(ready), 128'd1);
        check("abort_dout", data_out, '0);
        @(negedge clk);
        rst = 1'b0;

        issue(K1, P1, 1'b1, C1, 1'b1);

        for (int i = 0; i < 16; i++) begin
            k = rnd128();
            d = rnd128();
            e = 1'($urandom_range(0, 1));
            issue(k, d, e, ref_aes(k, d, e), 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            k = rnd128();
            d = rnd128();
            c = ref_aes(k, d, 1'b1);
            issue(k, d, 1'b1, c, 1'b1);
            issue(k, c, 1'b0, d, 1'b1);
        end

        // Start held high: captures on consecutive idle cycles, 23 cycles apart.
        t = 0;
        @(negedge clk);
        while (ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        k = rnd128();
        d = rnd128();
        key_in  = k;
        data_in = d;
        enc_dec = 1'b1;
        start   = 1'b1;
        exp_q.push_back(ref_aes(k, d, 1'b1));
        exp_q.push_back(ref_aes(k, d, 1'b1));
        @(posedge clk);
        repeat (23) @(posedge clk);
        #1;
        start = 1'b0;

        t = 0;
        while ((exp_q.size() != 0 || ready !== 1'b1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0 || ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
